// File: rtl/mem_stage_pkg.sv
// mem_stage shared types: FSM states, bus widths and the op flags carried through REQ.
// Build option: MEM_ALIGN_CHECK_EN (trap misaligned word accesses).
package mem_stage_pkg;

    localparam int REG_BUS_W      = 32;
    localparam int REG_ADDR_BUS_W = 5;
    localparam int MEM_ADDR_BUS_W = 32;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_REQ  = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic store;
        logic kill;
    } mem_op_t;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-bus req/ack interface between mem_stage (master) and memory (slave).
// Shared by every build, with or without MEM_ALIGN_CHECK_EN.
interface mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);

    logic              dbus_req;
    logic              dbus_we;
    logic [ADDR_W-1:0] dbus_addr;
    logic [DATA_W-1:0] dbus_wdata;
    logic              dbus_ack;
    logic [DATA_W-1:0] dbus_rdata;

    modport master (
        output dbus_req,
        output dbus_we,
        output dbus_addr,
        output dbus_wdata,
        input  dbus_ack,
        input  dbus_rdata
    );

    modport slave (
        input  dbus_req,
        input  dbus_we,
        input  dbus_addr,
        input  dbus_wdata,
        output dbus_ack,
        output dbus_rdata
    );

endinterface

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage, word load/store over req/ack bus, registered write-back.
// Build option: MEM_ALIGN_CHECK_EN traps misaligned accesses instead of issuing them.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = REG_BUS_W,
    parameter int ADDR_W  = MEM_ADDR_BUS_W,
    parameter int RADDR_W = REG_ADDR_BUS_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic [DATA_W-1:0]  ex_alu_result,
    input  logic               ex_mem_regfile_we,
    input  logic [RADDR_W-1:0] ex_mem_regfile_waddr,
    input  logic               ex_mem_re,
    input  logic               ex_mem_we,
    input  logic [ADDR_W-1:0]  ex_mem_mem_addr,
    input  logic [DATA_W-1:0]  ex_mem_wdata,
    input  logic               flush,
    output logic               stall_req,
    mem_stage_if.master        dbus,
    output logic               wb_valid,
    output logic               wb_regfile_we,
    output logic [RADDR_W-1:0] wb_regfile_waddr,
    output logic [DATA_W-1:0]  wb_regfile_wdata,
    output logic               mem_excp,
    output logic [ADDR_W-1:0]  mem_excp_addr
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    mem_state_e         state_q, state_d;
    mem_op_t            op_q, op_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [RADDR_W-1:0] waddr_q, waddr_d;

    logic               wb_vld_q, wb_vld_d;
    logic               wb_we_q, wb_we_d;
    logic [RADDR_W-1:0] wb_waddr_q, wb_waddr_d;
    logic [DATA_W-1:0]  wb_wdata_q, wb_wdata_d;

    logic accept;
    logic is_mem;
    logic bad_align;
    logic kill_now;

`ifdef MEM_ALIGN_CHECK_EN
    logic              excp_q, excp_d;
    logic [ADDR_W-1:0] excp_addr_q, excp_addr_d;
`endif

    assign is_mem   = ex_mem_re | ex_mem_we;
    assign accept   = ex_valid & ~flush;
    assign kill_now = op_q.kill | flush;

`ifdef MEM_ALIGN_CHECK_EN
    assign bad_align = is_mem & misaligned(ex_mem_mem_addr[1:0]);
`else
    assign bad_align = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        waddr_d    = waddr_q;
        wb_vld_d   = 1'b0;
        wb_we_d    = 1'b0;
        wb_waddr_d = wb_waddr_q;
        wb_wdata_d = wb_wdata_q;
`ifdef MEM_ALIGN_CHECK_EN
        excp_d      = 1'b0;
        excp_addr_d = excp_addr_q;
`endif
        unique case (state_q)
            MEM_IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        !is_mem: begin
                            wb_vld_d   = 1'b1;
                            wb_we_d    = ex_mem_regfile_we;
                            wb_waddr_d = ex_mem_regfile_waddr;
                            wb_wdata_d = ex_alu_result;
                        end
                        bad_align: begin
                            wb_vld_d   = 1'b1;
                            wb_waddr_d = ex_mem_regfile_waddr;
`ifdef MEM_ALIGN_CHECK_EN
                            excp_d      = 1'b1;
                            excp_addr_d = ex_mem_mem_addr;
`endif
                        end
                        default: begin
                            // store wins when both re and we are set
                            op_d.store = ex_mem_we;
                            op_d.kill  = 1'b0;
                            addr_d     = ex_mem_mem_addr & WORD_MASK;
                            wdata_d    = ex_mem_wdata;
                            waddr_d    = ex_mem_regfile_waddr;
                            state_d    = MEM_REQ;
                        end
                    endcase
                end
            end
            MEM_REQ: begin
                // a flush only marks the op; the handshake always completes
                if (flush) begin
                    op_d.kill = 1'b1;
                end
                if (dbus.dbus_ack) begin
                    state_d    = MEM_IDLE;
                    wb_vld_d   = ~kill_now;
                    wb_we_d    = ~op_q.store & ~kill_now;
                    wb_waddr_d = waddr_q;
                    if (!op_q.store && !kill_now) begin
                        wb_wdata_d = dbus.dbus_rdata;
                    end
                end
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= MEM_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            waddr_q    <= '0;
            wb_vld_q   <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_waddr_q <= '0;
            wb_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            waddr_q    <= waddr_d;
            wb_vld_q   <= wb_vld_d;
            wb_we_q    <= wb_we_d;
            wb_waddr_q <= wb_waddr_d;
            wb_wdata_q <= wb_wdata_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            excp_q      <= 1'b0;
            excp_addr_q <= '0;
        end else begin
            excp_q      <= excp_d;
            excp_addr_q <= excp_addr_d;
        end
    end

    assign mem_excp      = excp_q;
    assign mem_excp_addr = excp_addr_q;
`else
    assign mem_excp      = 1'b0;
    assign mem_excp_addr = '0;
`endif

    assign stall_req        = (state_q == MEM_REQ);
    assign dbus.dbus_req    = (state_q == MEM_REQ);
    assign dbus.dbus_we     = op_q.store;
    assign dbus.dbus_addr   = addr_q;
    assign dbus.dbus_wdata  = wdata_q;

    assign wb_valid         = wb_vld_q;
    assign wb_regfile_we    = wb_we_q;
    assign wb_regfile_waddr = wb_waddr_q;
    assign wb_regfile_wdata = wb_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed plan steps plus random op stream.
// Build option: MEM_ALIGN_CHECK_EN switches the misaligned-access expectations.
module tb_mem_stage;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;

    typedef struct {
        bit          mem;
        bit          store;
        bit          both;
        bit          rfwe;
        logic [4:0]  waddr;
        logic [31:0] alu;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        bit          flush_acc;
        bit          flush_req;
    } tb_op_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ex_valid = 1'b0;
    logic [DW-1:0] ex_alu_result = '0;
    logic          ex_mem_regfile_we = 1'b0;
    logic [RW-1:0] ex_mem_regfile_waddr = '0;
    logic          ex_mem_re = 1'b0;
    logic          ex_mem_we = 1'b0;
    logic [AW-1:0] ex_mem_mem_addr = '0;
    logic [DW-1:0] ex_mem_wdata = '0;
    logic          flush = 1'b0;
    logic          stall_req;
    logic          wb_valid;
    logic          wb_regfile_we;
    logic [RW-1:0] wb_regfile_waddr;
    logic [DW-1:0] wb_regfile_wdata;
    logic          mem_excp;
    logic [AW-1:0] mem_excp_addr;

    int n_assert = 0;
    int n_fail   = 0;

    // last register value known to be on the write-back bus
    logic [31:0] m_wdata = '0;
    bit          m_known = 1'b0;

    always #5 clk = ~clk;

    mem_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_stage #(.DATA_W(DW), .ADDR_W(AW), .RADDR_W(RW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ex_valid             (ex_valid),
        .ex_alu_result        (ex_alu_result),
        .ex_mem_regfile_we    (ex_mem_regfile_we),
        .ex_mem_regfile_waddr (ex_mem_regfile_waddr),
        .ex_mem_re            (ex_mem_re),
        .ex_mem_we            (ex_mem_we),
        .ex_mem_mem_addr      (ex_mem_mem_addr),
        .ex_mem_wdata         (ex_mem_wdata),
        .flush                (flush),
        .stall_req            (stall_req),
        .dbus                 (bus.master),
        .wb_valid             (wb_valid),
        .wb_regfile_we        (wb_regfile_we),
        .wb_regfile_waddr     (wb_regfile_waddr),
        .wb_regfile_wdata     (wb_regfile_wdata),
        .mem_excp             (mem_excp),
        .mem_excp_addr        (mem_excp_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_stall"}, 32'(stall_req), 32'd0);
        chk({tag, "_req"}, 32'(bus.dbus_req), 32'd0);
        chk({tag, "_we"}, 32'(bus.dbus_we), 32'd0);
        chk({tag, "_addr"}, bus.dbus_addr, 32'd0);
        chk({tag, "_bwdata"}, bus.dbus_wdata, 32'd0);
        chk({tag, "_wbv"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wbwe"}, 32'(wb_regfile_we), 32'd0);
        chk({tag, "_waddr"}, 32'(wb_regfile_waddr), 32'd0);
        chk({tag, "_wdata"}, wb_regfile_wdata, 32'd0);
        chk({tag, "_excp"}, 32'(mem_excp), 32'd0);
        chk({tag, "_eaddr"}, mem_excp_addr, 32'd0);
    endtask

    function automatic tb_op_t mkop(input bit mem, input bit store, input logic [4:0] wa,
                                    input logic [31:0] alu, input logic [31:0] addr,
                                    input logic [31:0] wd, input logic [31:0] rd,
                                    input int waits, input bit freq);
        tb_op_t o;
        o.mem = mem; o.store = store; o.both = 1'b0; o.rfwe = 1'b1;
        o.waddr = wa; o.alu = alu; o.addr = addr; o.wdata = wd; o.rdata = rd;
        o.waits = waits; o.flush_acc = 1'b0; o.flush_req = freq;
        return o;
    endfunction

    function automatic tb_op_t rand_op();
        tb_op_t o;
        o.mem       = ($urandom_range(0, 2) != 0);
        o.store     = ($urandom_range(0, 1) == 1);
        o.both      = o.store && ($urandom_range(0, 3) == 0);
        o.rfwe      = ($urandom_range(0, 1) == 1);
        o.waddr     = 5'($urandom);
        o.alu       = $urandom;
        o.addr      = $urandom;
        if ($urandom_range(0, 3) != 0) o.addr[1:0] = 2'b00;
        o.wdata     = $urandom;
        o.rdata     = $urandom;
        o.waits     = int'($urandom_range(0, 3));
        o.flush_acc = ($urandom_range(0, 7) == 0);
        o.flush_req = o.mem && ($urandom_range(0, 5) == 0);
        return o;
    endfunction

    // Called at a negedge with the stage idle; returns at the negedge showing write-back.
    task automatic issue(input string tag, input tb_op_t o);
        bit bad;
        bit killed;
        chk({tag, "_pre_stall"}, 32'(stall_req), 32'd0);
        ex_valid             = 1'b1;
        ex_alu_result        = o.alu;
        ex_mem_regfile_we    = o.rfwe;
        ex_mem_regfile_waddr = o.waddr;
        ex_mem_re            = o.mem && (!o.store || o.both);
        ex_mem_we            = o.mem && o.store;
        ex_mem_mem_addr      = o.addr;
        ex_mem_wdata         = o.wdata;
        flush                = o.flush_acc;
        bad = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        bad = o.mem && (o.addr[1:0] != 2'b00);
`endif
        @(negedge clk);
        if (o.flush_acc) begin
            chk({tag, "_fl_wbv"}, 32'(wb_valid), 32'd0);
            chk({tag, "_fl_wbwe"}, 32'(wb_regfile_we), 32'd0);
            chk({tag, "_fl_req"}, 32'(bus.dbus_req), 32'd0);
            chk({tag, "_fl_stall"}, 32'(stall_req), 32'd0);
        end else if (!o.mem) begin
            chk({tag, "_alu_wbv"}, 32'(wb_valid), 32'd1);
            chk({tag, "_alu_wbwe"}, 32'(wb_regfile_we), 32'(o.rfwe));
            chk({tag, "_alu_waddr"}, 32'(wb_regfile_waddr), 32'(o.waddr));
            chk({tag, "_alu_wdata"}, wb_regfile_wdata, o.alu);
            chk({tag, "_alu_stall"}, 32'(stall_req), 32'd0);
            chk({tag, "_alu_req"}, 32'(bus.dbus_req), 32'd0);
            chk({tag, "_alu_excp"}, 32'(mem_excp), 32'd0);
            m_wdata = o.alu;
            m_known = 1'b1;
        end else if (bad) begin
            chk({tag, "_mis_wbv"}, 32'(wb_valid), 32'd1);
            chk({tag, "_mis_wbwe"}, 32'(wb_regfile_we), 32'd0);
            chk({tag, "_mis_excp"}, 32'(mem_excp), 32'd1);
            chk({tag, "_mis_eaddr"}, mem_excp_addr, o.addr);
            chk({tag, "_mis_req"}, 32'(bus.dbus_req), 32'd0);
            chk({tag, "_mis_stall"}, 32'(stall_req), 32'd0);
            m_known = 1'b0;
        end else begin
            for (int k = 0; k <= o.waits; k++) begin
                ex_valid        = ($urandom_range(0, 1) == 1);
                ex_alu_result   = $urandom;
                ex_mem_re       = ($urandom_range(0, 1) == 1);
                ex_mem_we       = ($urandom_range(0, 1) == 1);
                ex_mem_mem_addr = $urandom;
                ex_mem_wdata    = $urandom;
                flush           = o.flush_req && (k == 0);
                chk({tag, "_req_stall"}, 32'(stall_req), 32'd1);
                chk({tag, "_req_req"}, 32'(bus.dbus_req), 32'd1);
                chk({tag, "_req_we"}, 32'(bus.dbus_we), 32'(o.store));
                chk({tag, "_req_addr"}, bus.dbus_addr, o.addr & ~32'd3);
                if (o.store) chk({tag, "_req_bwdata"}, bus.dbus_wdata, o.wdata);
                chk({tag, "_req_wbv"}, 32'(wb_valid), 32'd0);
                if (k == o.waits) begin
                    bus.dbus_ack   = 1'b1;
                    bus.dbus_rdata = o.rdata;
                end else begin
                    bus.dbus_ack   = 1'b0;
                    bus.dbus_rdata = $urandom;
                end
                @(negedge clk);
                bus.dbus_ack = 1'b0;
                flush        = 1'b0;
            end
            killed = o.flush_req;
            chk({tag, "_done_stall"}, 32'(stall_req), 32'd0);
            chk({tag, "_done_req"}, 32'(bus.dbus_req), 32'd0);
            chk({tag, "_done_wbv"}, 32'(wb_valid), 32'(!killed));
            chk({tag, "_done_wbwe"}, 32'(wb_regfile_we), 32'(!o.store && !killed));
            chk({tag, "_done_excp"}, 32'(mem_excp), 32'd0);
            if (!o.store && !killed) begin
                chk({tag, "_ld_waddr"}, 32'(wb_regfile_waddr), 32'(o.waddr));
                chk({tag, "_ld_wdata"}, wb_regfile_wdata, o.rdata);
                m_wdata = o.rdata;
                m_known = 1'b1;
            end else begin
                m_known = 1'b0;
            end
        end
        ex_valid  = 1'b0;
        ex_mem_re = 1'b0;
        ex_mem_we = 1'b0;
        flush     = 1'b0;
    endtask

    // One cycle with no instruction; stray acks and flushes must not disturb anything.
    task automatic idle(input string tag);
        ex_valid       = 1'b0;
        flush          = ($urandom_range(0, 1) == 1);
        bus.dbus_ack   = ($urandom_range(0, 1) == 1);
        bus.dbus_rdata = $urandom;
        @(negedge clk);
        bus.dbus_ack = 1'b0;
        flush        = 1'b0;
        chk({tag, "_wbv"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wbwe"}, 32'(wb_regfile_we), 32'd0);
        chk({tag, "_stall"}, 32'(stall_req), 32'd0);
        chk({tag, "_req"}, 32'(bus.dbus_req), 32'd0);
        if (m_known) chk({tag, "_hold"}, wb_regfile_wdata, m_wdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tb_op_t o;
        bus.dbus_ack   = 1'b0;
        bus.dbus_rdata = '0;
        #1 rst = 1'b0;
        #2 chk_reset("reset");
        @(negedge clk);
        rst = 1'b1;
        m_wdata = '0;
        m_known = 1'b1;

        issue("or_ff", mkop(1'b0, 1'b0, 5'd3, 32'h0000_00FF, '0, '0, '0, 0, 1'b0));
        idle("idle0");
        issue("ld100", mkop(1'b1, 1'b0, 5'd9, '0, 32'h100, '0, 32'hDEAD_BEEF, 3, 1'b0));
        idle("idle1");
        issue("st200", mkop(1'b1, 1'b1, 5'd4, '0, 32'h200, 32'h1234_5678, '0, 0, 1'b0));
        issue("held", mkop(1'b0, 1'b0, 5'd7, 32'h0000_0055, '0, '0, '0, 0, 1'b0));
        issue("ldfl", mkop(1'b1, 1'b0, 5'd12, '0, 32'h400, '0, 32'hCAFE_F00D, 2, 1'b1));
        idle("idle2");
        o = mkop(1'b1, 1'b1, 5'd5, '0, 32'h500, 32'hA5A5_0001, '0, 1, 1'b0);
        o.both = 1'b1;
        issue("both", o);
        o = mkop(1'b0, 1'b0, 5'd8, 32'h1111_2222, '0, '0, '0, 0, 1'b0);
        o.flush_acc = 1'b1;
        issue("flacc", o);
        issue("mis102", mkop(1'b1, 1'b0, 5'd6, '0, 32'h102, '0, 32'h0BAD_0BAD, 1, 1'b0));
        idle("idle3");

        // asynchronous reset in the middle of a store handshake
        ex_valid             = 1'b1;
        ex_mem_we            = 1'b1;
        ex_mem_re            = 1'b0;
        ex_mem_mem_addr      = 32'h300;
        ex_mem_wdata         = 32'h7777_8888;
        ex_mem_regfile_waddr = 5'd2;
        @(negedge clk);
        chk("rstmid_req", 32'(bus.dbus_req), 32'd1);
        ex_valid  = 1'b0;
        ex_mem_we = 1'b0;
        #2 rst = 1'b0;
        #1 chk_reset("rstmid");
        @(negedge clk);
        rst = 1'b1;
        m_wdata = '0;
        m_known = 1'b1;
        idle("idle4");
        issue("post_rst", mkop(1'b0, 1'b0, 5'd31, 32'h0F0F_0F0F, '0, '0, '0, 0, 1'b0));

        for (int i = 0; i < 80; i++) begin
            issue("rnd", rand_op());
            if ($urandom_range(0, 3) == 0) idle("rnd_idle");
        end
        idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
